// File: rtl/slave_piso_tx.sv
// I2C slave transmit shifter: buffers one byte and shifts it MSB-first onto SDA for master reads.
// Optional clock stretching on empty buffer is enabled by defining SLAVE_TX_CLK_STRETCH_EN.
module slave_piso_tx #(
    parameter int                DATA_W        = 8,
    parameter logic [DATA_W-1:0] UNDERRUN_BYTE = {DATA_W{1'b1}}
) (
    input  logic              slave_scl_sixt,
    input  logic              slave_rst_n,
    input  logic              slave_scl,
    input  logic              slave_sda_in,
    input  logic              slave_tx_start,
    input  logic              slave_stop,
    input  logic [DATA_W-1:0] slave_tx_data,
    input  logic              slave_tx_valid,
    output logic              slave_tx_ready,
    output logic              slave_sda_oe,
    output logic              slave_scl_oe,
    output logic              slave_tx_busy,
    output logic              slave_ack_rcvd,
    output logic              slave_nack_rcvd,
    output logic              slave_tx_underrun
);

    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SHIFT    = 3'd1;
    localparam logic [2:0] ST_ACK      = 3'd2;
    localparam logic [2:0] ST_ACK_WAIT = 3'd3;
`ifdef SLAVE_TX_CLK_STRETCH_EN
    localparam logic [2:0] ST_STRETCH  = 3'd4;
`endif

    logic [2:0]        state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] buf_data;
    logic              buf_full;
    logic              scl_d;

    logic fall;
    logic rise;
    logic accept;
    logic load_pt;
    logic have_byte;
    logic stretch_load;
    logic [DATA_W-1:0] load_data;

    assign fall      = scl_d & ~slave_scl;
    assign rise      = ~scl_d & slave_scl;
    assign accept    = slave_tx_valid & ~buf_full;
    assign load_pt   = ~slave_stop & (((state == ST_IDLE) & slave_tx_start) |
                                      ((state == ST_ACK_WAIT) & fall));
    assign have_byte = buf_full | accept;
    // A byte arriving exactly at a load point bypasses the buffer.
    assign load_data = buf_full ? buf_data : slave_tx_data;

`ifdef SLAVE_TX_CLK_STRETCH_EN
    assign stretch_load = ~slave_stop & (state == ST_STRETCH) & accept;
`else
    assign stretch_load = 1'b0;
`endif

    assign slave_tx_ready = ~buf_full;
    assign slave_tx_busy  = (state != ST_IDLE);

    always_ff @(posedge slave_scl_sixt or negedge slave_rst_n) begin
        if (!slave_rst_n) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else if (load_pt || stretch_load) begin
            buf_full <= 1'b0;
        end else if (accept) begin
            buf_full <= 1'b1;
            buf_data <= slave_tx_data;
        end
    end

    always_ff @(posedge slave_scl_sixt or negedge slave_rst_n) begin
        if (!slave_rst_n) begin
            state             <= ST_IDLE;
            shreg             <= '0;
            bit_cnt           <= '0;
            scl_d             <= 1'b1;
            slave_sda_oe      <= 1'b0;
            slave_ack_rcvd    <= 1'b0;
            slave_nack_rcvd   <= 1'b0;
            slave_tx_underrun <= 1'b0;
        end else begin
            scl_d             <= slave_scl;
            slave_ack_rcvd    <= 1'b0;
            slave_nack_rcvd   <= 1'b0;
            slave_tx_underrun <= 1'b0;
            // SDA follows the state one clock late so it only moves well inside SCL low.
            slave_sda_oe      <= ~slave_stop & (state == ST_SHIFT) & ~shreg[DATA_W-1];

            if (slave_stop) begin
                state <= ST_IDLE;
            end else if (load_pt) begin
                if (have_byte) begin
                    shreg   <= load_data;
                    bit_cnt <= CNT_W'(DATA_W - 1);
                    state   <= ST_SHIFT;
                end else begin
`ifdef SLAVE_TX_CLK_STRETCH_EN
                    state             <= ST_STRETCH;
`else
                    shreg             <= UNDERRUN_BYTE;
                    bit_cnt           <= CNT_W'(DATA_W - 1);
                    state             <= ST_SHIFT;
                    slave_tx_underrun <= 1'b1;
`endif
                end
            end else begin
                case (state)
                    ST_SHIFT: begin
                        if (fall) begin
                            if (bit_cnt == '0) begin
                                state <= ST_ACK;
                            end else begin
                                shreg   <= {shreg[DATA_W-2:0], 1'b0};
                                bit_cnt <= bit_cnt - 1'b1;
                            end
                        end
                    end
                    ST_ACK: begin
                        if (rise) begin
                            if (!slave_sda_in) begin
                                slave_ack_rcvd <= 1'b1;
                                state          <= ST_ACK_WAIT;
                            end else begin
                                slave_nack_rcvd <= 1'b1;
                                state           <= ST_IDLE;
                            end
                        end
                    end
`ifdef SLAVE_TX_CLK_STRETCH_EN
                    ST_STRETCH: begin
                        if (accept) begin
                            shreg   <= slave_tx_data;
                            bit_cnt <= CNT_W'(DATA_W - 1);
                            state   <= ST_SHIFT;
                        end
                    end
`endif
                    ST_IDLE, ST_ACK_WAIT: ;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef SLAVE_TX_CLK_STRETCH_EN
    always_ff @(posedge slave_scl_sixt or negedge slave_rst_n) begin
        if (!slave_rst_n) begin
            slave_scl_oe <= 1'b0;
        end else begin
            slave_scl_oe <= ~slave_stop & (state == ST_STRETCH);
        end
    end
`else
    assign slave_scl_oe = 1'b0;
`endif

endmodule
